cp_bypass: RTL
==============

Name: cp_bypass

Overview:
- Operand bypass and ID/EX operand-register stage of the CP pipeline.
- Sits directly downstream of the CP register file. Takes the two combinational RF read values plus in-flight results from EX and WB, and selects the freshest value for each operand.
- Registers the selected operands into EX and detects load-use hazards, inserting one bubble per hazard.
- While the pipeline is frozen, snoops WB writes so held operands never go stale.

Parameters:
- DATA_WIDTH, 32, CP datapath width.
- RF_INDEX_WIDTH, 5, register index width (register 0 is hard-wired zero).

Ports:
- iClk  in  1  system clock, posedge.
- iReset_n  in  1  asynchronous active-low reset.
- iID_Valid  in  1  ID stage holds a valid instruction.
- iID_Read_Addr_A  in  RF_INDEX_WIDTH  source A index; same value that drove RF port A this cycle.
- iID_Read_Addr_B  in  RF_INDEX_WIDTH  source B index.
- iID_Use_A  in  1  instruction reads source A.
- iID_Use_B  in  1  instruction reads source B.
- iRF_Read_Data_A  in  DATA_WIDTH  RF port A read data.
- iRF_Read_Data_B  in  DATA_WIDTH  RF port B read data.
- iEX_Write_Enable  in  1  instruction in EX writes the RF.
- iEX_Write_Addr  in  RF_INDEX_WIDTH  EX destination.
- iEX_Is_Load  in  1  EX instruction is a load (result not yet available).
- iEX_Result  in  DATA_WIDTH  EX ALU result.
- iWB_Write_Enable  in  1  same signal as the RF write enable.
- iWB_Write_Addr  in  RF_INDEX_WIDTH  WB destination.
- iWB_Write_Data  in  DATA_WIDTH  WB data.
- iStall  in  1  downstream freeze; holds the EX operand registers.
- oBP_Stall  out  1  load-use stall request to IF/ID (combinational).
- oBP_EX_Valid  out  1  EX operands valid (registered).
- oBP_EX_Operand_A  out  DATA_WIDTH  registered operand A.
- oBP_EX_Operand_B  out  DATA_WIDTH  registered operand B.

Behaviour:
- Reset (async, iReset_n=0):
  - oBP_EX_Valid=0.
  - Both operands = 0.
  - Captured source indices = 0.
  - Stall-count register = 0.
  - Reset mid-stall drops the bubble and any pending instruction.
- Operand select, per operand X (combinational):
  - If Addr_X==0: value is 0.
  - Else if iEX_Write_Enable && !iEX_Is_Load && iEX_Write_Addr==Addr_X: iEX_Result.
  - Else if iWB_Write_Enable && iWB_Write_Addr==Addr_X: iWB_Write_Data.
  - Else: iRF_Read_Data_X.
  - Priority is EX > WB > RF.
- Load-use hazard:
  - Condition: hz = iID_Valid && iEX_Write_Enable && iEX_Is_Load && iEX_Write_Addr!=0 && ((iID_Use_A && iEX_Write_Addr==iID_Read_Addr_A) || (iID_Use_B && iEX_Write_Addr==iID_Read_Addr_B)).
  - oBP_Stall = hz && !iStall.
- Register update on posedge, when iStall=0:
  - oBP_EX_Valid <= iID_Valid && !hz.
  - Operands <= selected values.
  - Source indices captured.
  - With hz=1: a bubble is inserted (Valid=0) and ID is held by oBP_Stall. Next cycle the load sits in WB and the operand is forwarded from WB.
  - Latency: ID to EX operands = 1 cycle.
- Freeze (iStall=1):
  - Valid and operands hold.
  - Snoop: if iWB_Write_Enable && iWB_Write_Addr==captured index X && index!=0, operand X <= iWB_Write_Data.
  - Both operands may update in the same cycle.
  - oBP_Stall forced 0; the freeze dominates.
- Simultaneous events:
  - EX and WB both target Addr_X: EX wins.
  - A load in EX targeting an unused source (Use_X=0) causes no stall.
  - Writes to r0 are never forwarded or snooped.
- Widths: equality compares on the full RF_INDEX_WIDTH; no arithmetic.

Optional Feature:
- Macro: CP_BP_STALL_COUNT_EN.
- Defined:
  - Adds output oBP_Stall_Count [15:0].
  - Increments on each cycle where oBP_Stall=1.
  - Saturates at 16'hFFFF.
  - Reset to 0 asynchronously.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- RF-only path: RF A=32'h11, B=32'h22, Addr 3/4, no EX/WB writes, iID_Valid=1 → next cycle Operand_A=32'h11, Operand_B=32'h22, Valid=1.
- Priority: EX writes r5=32'hAAAA (non-load), WB writes r5=32'hBBBB, RF=32'hCCCC, Addr_A=5 → Operand_A=32'hAAAA. Repeat with EX disabled → 32'hBBBB.
- Load-use: EX load to r7, ID reads A=r7 with Use_A=1 → oBP_Stall=1 for exactly 1 cycle and Valid=0 next cycle. Following cycle WB writes r7=32'h1234 → Operand_A=32'h1234, Valid=1. Counter=1 if CP_BP_STALL_COUNT_EN.
- r0 and unused source: EX load to r0, or Use_B=0 with Addr_B matching → no stall. Addr_A=0 with WB writing r0=32'hFF → Operand_A=0.
- Freeze snoop: capture Addr_A=9 with value 32'h5. Assert iStall, WB writes r9=32'h77 → Operand_A=32'h77, Valid held. Release iStall → normal advance.
- Async reset mid-hazard: assert iReset_n=0 while oBP_Stall=1 → Valid=0, operands=0, counter=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp_bypass.sv
// cp_bypass: ID/EX operand bypass with load-use bubble insertion and WB snooping while frozen.
// Optional `CP_BP_STALL_COUNT_EN adds a saturating 16-bit load-use stall counter output.
module cp_bypass #(
    parameter int DATA_WIDTH     = 32,
    parameter int RF_INDEX_WIDTH = 5
) (
    input  logic                      iClk,
    input  logic                      iReset_n,
    input  logic                      iID_Valid,
    input  logic [RF_INDEX_WIDTH-1:0] iID_Read_Addr_A,
    input  logic [RF_INDEX_WIDTH-1:0] iID_Read_Addr_B,
    input  logic                      iID_Use_A,
    input  logic                      iID_Use_B,
    input  logic [DATA_WIDTH-1:0]     iRF_Read_Data_A,
    input  logic [DATA_WIDTH-1:0]     iRF_Read_Data_B,
    input  logic                      iEX_Write_Enable,
    input  logic [RF_INDEX_WIDTH-1:0] iEX_Write_Addr,
    input  logic                      iEX_Is_Load,
    input  logic [DATA_WIDTH-1:0]     iEX_Result,
    input  logic                      iWB_Write_Enable,
    input  logic [RF_INDEX_WIDTH-1:0] iWB_Write_Addr,
    input  logic [DATA_WIDTH-1:0]     iWB_Write_Data,
    input  logic                      iStall,
    output logic                      oBP_Stall,
    output logic                      oBP_EX_Valid,
    output logic [DATA_WIDTH-1:0]     oBP_EX_Operand_A,
    output logic [DATA_WIDTH-1:0]     oBP_EX_Operand_B
`ifdef CP_BP_STALL_COUNT_EN
    ,
    output logic [15:0]               oBP_Stall_Count
`endif
);
    localparam logic [RF_INDEX_WIDTH-1:0] R0 = '0;

    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [RF_INDEX_WIDTH-1:0] idx_a_q, idx_a_d, idx_b_q, idx_b_d;
    logic [DATA_WIDTH-1:0]     sel_a, sel_b;
    logic                      ex_fwd, hz, snoop_a, snoop_b;
    logic [15:0]               cnt_q, cnt_d;

    always_comb begin
        // a load's result is not ready in EX, so only non-load EX results are forwarded
        ex_fwd = iEX_Write_Enable && !iEX_Is_Load;
        sel_a = (iID_Read_Addr_A == R0) ? '0 :
                (ex_fwd && iEX_Write_Addr == iID_Read_Addr_A) ? iEX_Result :
                (iWB_Write_Enable && iWB_Write_Addr == iID_Read_Addr_A) ? iWB_Write_Data :
                iRF_Read_Data_A;
        sel_b = (iID_Read_Addr_B == R0) ? '0 :
                (ex_fwd && iEX_Write_Addr == iID_Read_Addr_B) ? iEX_Result :
                (iWB_Write_Enable && iWB_Write_Addr == iID_Read_Addr_B) ? iWB_Write_Data :
                iRF_Read_Data_B;
        hz = iID_Valid && iEX_Write_Enable && iEX_Is_Load && iEX_Write_Addr != R0 &&
             ((iID_Use_A && iEX_Write_Addr == iID_Read_Addr_A) ||
              (iID_Use_B && iEX_Write_Addr == iID_Read_Addr_B));
        oBP_Stall = hz && !iStall;
        snoop_a = iWB_Write_Enable && iWB_Write_Addr == idx_a_q && idx_a_q != R0;
        snoop_b = iWB_Write_Enable && iWB_Write_Addr == idx_b_q && idx_b_q != R0;
        valid_d = iStall ? valid_q : (iID_Valid && !hz);
        op_a_d  = iStall ? (snoop_a ? iWB_Write_Data : op_a_q) : sel_a;
        op_b_d  = iStall ? (snoop_b ? iWB_Write_Data : op_b_q) : sel_b;
        idx_a_d = iStall ? idx_a_q : iID_Read_Addr_A;
        idx_b_d = iStall ? idx_b_q : iID_Read_Addr_B;
        cnt_d   = (oBP_Stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            valid_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            idx_a_q <= '0;
            idx_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            idx_a_q <= idx_a_d;
            idx_b_q <= idx_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oBP_EX_Valid     = valid_q;
    assign oBP_EX_Operand_A = op_a_q;
    assign oBP_EX_Operand_B = op_b_q;
`ifdef CP_BP_STALL_COUNT_EN
    assign oBP_Stall_Count  = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif
endmodule
